// File: rtl/gpio_master_pkg.sv
// Shared types for the GPIO bus master: command opcodes, FSM states and default widths.
package gpio_master_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_RMW    = 2'b10,
        OP_TOGGLE = 2'b11
    } gpioOpT;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RESP
    } masterStateT;

endpackage

// File: rtl/gpio_bus_master_if.sv
// Command/response channel and GPIO register port of the bus master, bundled in one interface.
interface gpio_bus_master_if
    import gpio_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DATA_W / 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BE_W-1:0]   cmd_be;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_mask;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] bus_addr_in;
    logic [ADDR_W-1:0] bus_addr_out;
    logic [BE_W-1:0]   bus_size_decode;
    logic [DATA_W-1:0] bus_data_in;
    logic [DATA_W-1:0] bus_data_out;

    // The master's view: commands in, responses and GPIO strobes out.
    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_be, cmd_wdata, cmd_mask,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output bus_addr_in, bus_addr_out, bus_size_decode, bus_data_in,
        input  bus_data_out
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_be, cmd_wdata, cmd_mask,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  bus_addr_in, bus_addr_out, bus_size_decode,
        input  bus_data_in,
        output bus_data_out
    );

endinterface

// File: rtl/gpio_rmw_merge.sv
// Combinational new-value generator for read-modify-write and toggle commands.
module gpio_rmw_merge
    import gpio_master_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] oldData,
    input  logic [DATA_W-1:0] wrData,
    input  logic [DATA_W-1:0] mask,
    input  gpioOpT            op,
    output logic [DATA_W-1:0] newData
);

    always_comb begin
        newData = oldData;
        case (op)
            OP_RMW:    newData = (oldData & ~mask) | (wrData & mask);
            OP_TOGGLE: newData = oldData ^ mask;
            default:   newData = oldData;
        endcase
    end

endmodule

// File: rtl/gpio_bus_master.sv
// Command-driven initiator for a GPIO register port (write/read/RMW/toggle).
// Define GPIO_MASTER_RMW_EN to build RMW/toggle support; otherwise those ops return rsp_err.
module gpio_bus_master
    import gpio_master_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BE_W         = DATA_W / 8,
    parameter int READ_LATENCY = 1
) (
    input logic               clk,
    input logic               rst,
    gpio_bus_master_if.master bus
);

    // Read phase counts down from READ_LATENCY-1; capture happens when it reaches zero.
    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    masterStateT       stateQ, stateD;
    logic [1:0]        waitQ, waitD;
    logic              cmdReadyQ, cmdReadyD;
    logic              rspValidQ, rspValidD;
    logic [DATA_W-1:0] rspRdataQ, rspRdataD;
    logic              rspErrQ, rspErrD;
    logic [ADDR_W-1:0] busAddrInQ, busAddrInD;
    logic [ADDR_W-1:0] busAddrOutQ, busAddrOutD;
    logic [BE_W-1:0]   busSizeQ, busSizeD;
    logic [DATA_W-1:0] busDataInQ, busDataInD;
    gpioOpT            cmdOp;

    assign cmdOp = gpioOpT'(bus.cmd_op);

`ifdef GPIO_MASTER_RMW_EN
    gpioOpT            opQ;
    logic [BE_W-1:0]   beQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] maskQ;
    logic [DATA_W-1:0] mergedData;

    // Command fields only needed after the read phase; pure data, so no reset.
    always_ff @(posedge clk) begin
        if (bus.cmd_valid && cmdReadyQ) begin
            opQ    <= cmdOp;
            beQ    <= bus.cmd_be;
            wdataQ <= bus.cmd_wdata;
            maskQ  <= bus.cmd_mask;
        end
    end

    gpio_rmw_merge #(
        .DATA_W (DATA_W)
    ) uMerge (
        .oldData (bus.bus_data_out),
        .wrData  (wdataQ),
        .mask    (maskQ),
        .op      (opQ),
        .newData (mergedData)
    );
`endif

    always_comb begin
        stateD      = stateQ;
        waitD       = waitQ;
        rspValidD   = rspValidQ;
        rspRdataD   = rspRdataQ;
        rspErrD     = rspErrQ;
        busAddrInD  = busAddrInQ;
        busAddrOutD = busAddrOutQ;
        busDataInD  = busDataInQ;
        busSizeD    = '0;

        case (stateQ)
            IDLE: begin
                if (bus.cmd_valid) begin
                    rspRdataD = '0;
                    rspErrD   = 1'b0;
                    case (cmdOp)
                        OP_WRITE: begin
                            stateD     = WR;
                            busAddrInD = bus.cmd_addr;
                            busDataInD = bus.cmd_wdata;
                            busSizeD   = bus.cmd_be;
                        end
                        OP_READ: begin
                            stateD      = RD;
                            busAddrOutD = bus.cmd_addr;
                            waitD       = WAIT_INIT;
                        end
                        default: begin
`ifdef GPIO_MASTER_RMW_EN
                            stateD      = RD;
                            busAddrOutD = bus.cmd_addr;
                            waitD       = WAIT_INIT;
`else
                            stateD    = RESP;
                            rspValidD = 1'b1;
                            rspErrD   = 1'b1;
`endif
                        end
                    endcase
                end
            end
            RD, RD_WAIT: begin
                if (waitQ == 2'd0) begin
                    rspRdataD = bus.bus_data_out;
`ifdef GPIO_MASTER_RMW_EN
                    if (opQ == OP_READ) begin
                        stateD    = RESP;
                        rspValidD = 1'b1;
                    end else begin
                        // Write back to the address still held on the read port.
                        stateD     = WR;
                        busAddrInD = busAddrOutQ;
                        busDataInD = mergedData;
                        busSizeD   = beQ;
                    end
`else
                    stateD    = RESP;
                    rspValidD = 1'b1;
`endif
                end else begin
                    waitD  = waitQ - 2'd1;
                    stateD = RD_WAIT;
                end
            end
            WR: begin
                stateD    = RESP;
                rspValidD = 1'b1;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    stateD    = IDLE;
                    rspValidD = 1'b0;
                end
            end
            default: stateD = IDLE;
        endcase

        cmdReadyD = (stateD == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= IDLE;
            waitQ       <= '0;
            cmdReadyQ   <= 1'b1;
            rspValidQ   <= 1'b0;
            rspRdataQ   <= '0;
            rspErrQ     <= 1'b0;
            busAddrInQ  <= '0;
            busAddrOutQ <= '0;
            busSizeQ    <= '0;
            busDataInQ  <= '0;
        end else begin
            stateQ      <= stateD;
            waitQ       <= waitD;
            cmdReadyQ   <= cmdReadyD;
            rspValidQ   <= rspValidD;
            rspRdataQ   <= rspRdataD;
            rspErrQ     <= rspErrD;
            busAddrInQ  <= busAddrInD;
            busAddrOutQ <= busAddrOutD;
            busSizeQ    <= busSizeD;
            busDataInQ  <= busDataInD;
        end
    end

    assign bus.cmd_ready       = cmdReadyQ;
    assign bus.rsp_valid       = rspValidQ;
    assign bus.rsp_rdata       = rspRdataQ;
    assign bus.rsp_err         = rspErrQ;
    assign bus.bus_addr_in     = busAddrInQ;
    assign bus.bus_addr_out    = busAddrOutQ;
    assign bus.bus_size_decode = busSizeQ;
    assign bus.bus_data_in     = busDataInQ;

endmodule

// File: doc/gpio_bus_master.md
Name: gpio_bus_master

Overview:
- Command-driven initiator for the GPIO peripheral's register interface.
- Drives write address, read address, byte-enable and write data into a GPIO port, and captures read data back.
- Accepts write, read, read-modify-write (RMW) and toggle commands over a valid/ready command channel; returns results on a valid/ready response channel.
- Sits between a sequencer/CPU-side agent and one GPIO instance, replacing hand-driven register pokes.

Parameters:
- ADDR_W, 8, width of GPIO register address.
- DATA_W, 32, width of GPIO data.
- BE_W, DATA_W/8 (4), byte-enable width.
- READ_LATENCY, 1, cycles from bus_addr_out change to valid bus_data_out (legal 1..3).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept command.
- cmd_op  in  2  00 write, 01 read, 10 RMW, 11 toggle.
- cmd_addr  in  ADDR_W  target register.
- cmd_be  in  BE_W  byte enables for write/RMW/toggle.
- cmd_wdata  in  DATA_W  write data (RMW: insert value).
- cmd_mask  in  DATA_W  bit mask (RMW/toggle).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read value (read/RMW/toggle: pre-modify value; write: 0).
- rsp_err  out  1  unsupported op.
- bus_addr_in  out  ADDR_W  GPIO write address.
- bus_addr_out  out  ADDR_W  GPIO read address.
- bus_size_decode  out  BE_W  GPIO byte enables; nonzero means write this cycle.
- bus_data_in  out  DATA_W  GPIO write data.
- bus_data_out  in  DATA_W  GPIO read data.

Behaviour:
- Reset (sync, high): state IDLE; cmd_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; all bus_* outputs 0.
- All outputs registered. cmd_ready=1 only in IDLE. Accept = cmd_valid & cmd_ready; the command is latched.
- States: IDLE, RD, RD_WAIT, WR, RESP.
- write: IDLE -> WR. For exactly one cycle: bus_addr_in=addr, bus_data_in=wdata, bus_size_decode=be. Then -> RESP.
- read: IDLE -> RD. bus_addr_out=addr is held for READ_LATENCY cycles (RD then RD_WAIT as needed). bus_data_out is captured on the last of them. Then -> RESP.
- RMW: read phase as above. Then WR with bus_data_in = (old & ~mask) | (wdata & mask) and bus_size_decode=be. Then RESP; rsp_rdata=old.
- toggle: read phase as above. Then WR with bus_data_in = old ^ mask. Then RESP.
- bus_size_decode is 0 in every state except WR. bus_addr_in and bus_data_in hold their last value outside WR; bus_addr_out holds its last value.
- Latency from accept to rsp_valid:
  - write: 2 cycles.
  - read: READ_LATENCY+1 cycles.
  - RMW/toggle: READ_LATENCY+2 cycles.
- RESP: rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready. On handshake -> IDLE; cmd_ready rises the next cycle (no same-cycle turnaround).
- be=0 on write/RMW/toggle: WR cycle still occupied, but no GPIO write (size_decode=0); normal response.
- Reset mid-operation: the next edge forces IDLE and zeroes bus_size_decode. No write issues after reset asserts; any pending response is dropped.
- cmd_* inputs are ignored when cmd_ready=0.

Optional Feature:
- Macro GPIO_MASTER_RMW_EN.
- Defined: ops 10/11 behave as above.
- Undefined: ops 10/11 do no bus activity; IDLE -> RESP with rsp_err=1, rsp_rdata=0; the merge logic is not synthesized.
- Ops 00/01 are identical in both builds; rsp_err is always 0 for them.

Decomposition:
- Package gpio_master_pkg: op encodings (OP_WRITE, OP_READ, OP_RMW, OP_TOGGLE), state encoding, default ADDR_W/DATA_W.
- One sub-module, gpio_rmw_merge: combinational (old, wdata, mask, op) -> new data. Instantiated only under GPIO_MASTER_RMW_EN.

Test Plan:
- Reset then write addr 2, be 4'hF, data 32'h00550055 -> one cycle with bus_addr_in=2, size_decode=F, data_in=00550055; rsp_valid 2 cycles after accept; rsp_rdata=0.
- Read addr 1 with GPIO model returning 32'hFFFFFFFF, READ_LATENCY=1 -> bus_addr_out=1; rsp_rdata=FFFFFFFF; size_decode stays 0 throughout.
- RMW addr 0, old 32'h12345678, wdata 32'h0000AB00, mask 32'h0000FF00 -> write data 1234AB78; rsp_rdata 12345678. Without macro: no bus write, rsp_err=1.
- Toggle addr 0, old 32'h000000F0, mask 32'h000000FF, be 4'h1 -> data_in 0000000F, size_decode=1.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0. Release -> cmd_ready=1 the next cycle.
- Assert rst on the cycle RMW enters RD_WAIT (READ_LATENCY=2) -> IDLE next cycle; no nonzero size_decode ever issued; rsp_valid=0.
